rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Shares one single-ported, synchronous-read word memory (1-cycle read latency) between the pipeline's instruction-fetch port (I) and MEM-stage data port (D).
- Data port has fixed priority.
- An anti-starvation counter bounds fetch stalls.
- Issues at most one memory transaction per cycle, fully pipelined, so back-to-back grants are allowed.
- Steers each response to its owner one cycle later.
- Sits between the core and the rv32i memory block.

Parameters:
STARVE_LIMIT, 4, consecutive cycles I may be denied before it wins the next arbitration (range 1..15)
ADDR_W, 32, address width of requester and memory ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
i_req  input  1  fetch request; held with i_addr stable until i_gnt
i_addr  input  ADDR_W  fetch byte address
i_flush  input  1  discard the fetch response due this cycle (branch redirect)
i_gnt  output  1  fetch accepted this cycle
i_rvalid  output  1  fetch data valid
i_rdata  output  32  fetch data
d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data byte address
d_wdata  input  32  store data
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid, or store acknowledge
d_rdata  output  32  load data (0 for stores and errors)
d_err  output  1  misaligned access, qualified by d_rvalid
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory byte address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid the cycle after mem_read

Behaviour:
- Reset (rst low, asynchronous):
  - resp_owner = NONE, resp_err = 0, starve_cnt = 0.
  - All outputs 0, including combinational grants, which are gated by rst.
  - A response in flight is dropped; no rvalid follows reset release.
- Arbitration (combinational, same cycle):
  - Rule 1: if d_req and not (i_req and starve_cnt == STARVE_LIMIT), then d_gnt = 1.
  - Rule 2: otherwise, if i_req, then i_gnt = 1.
  - i_gnt and d_gnt are never both 1.
- Misaligned data access (d_req with d_addr[1:0] != 0):
  - Granted per the rules above.
  - No memory strobe is issued; resp_err is set.
  - That cycle is free for I: if i_req, I is also granted and i_gnt = 1 (the only case with two grants in one cycle).
  - Fetch addresses are always word-aligned; i_addr[1:0] is ignored.
- Memory drive:
  - mem_read/mem_write/mem_addr/mem_wdata follow the granted request in the grant cycle.
  - mem_write = d_gnt & d_we & aligned.
  - With no grant, all mem_* outputs are 0.
- Response (registered owner):
  - resp_owner and resp_err capture the grant at the clock edge.
  - Next cycle:
    - owner I: i_rvalid = ~i_flush, i_rdata = mem_rdata.
    - owner D, load: d_rvalid = 1, d_rdata = mem_rdata.
    - owner D, store: d_rvalid = 1, d_rdata = 0.
    - owner D, error: d_rvalid = 1, d_err = 1, d_rdata = 0.
  - Response data not selected is driven 0.
- Latency: grant-to-rvalid is exactly 1 cycle, with sustained throughput of 1 transaction per cycle.
- Starvation counter (4-bit, saturating at STARVE_LIMIT):
  - +1 each cycle with i_req & ~i_gnt.
  - Cleared on i_gnt.
  - Holds when ~i_req.
- Flush:
  - i_flush has effect only on the I response cycle; it does not cancel a same-cycle grant.
  - A grant issued during a flush cycle responds normally next cycle.
- Simultaneous events:
  - Store granted then load to the same address granted next cycle: the load returns the new data, since the memory writes before it reads.
  - Requests dropped before grant are a protocol violation (checked by a bench assertion, not handled).

Decomposition:
- Package rv32i_mem_pkg holds:
  - owner encoding: OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D_RD = 2'd2, OWN_D_WR = 2'd3.
  - constant RV32I_NOP = 32'h00000013.
  - width of starve_cnt.
- One sub-module, rv32i_arb_starve: the saturating counter plus the priority-override compare, with outputs i_prio.

Test Plan:
- Reset: drive rst low mid-load (owner D) -> d_rvalid stays 0 after release; all mem_* = 0 and starve_cnt = 0.
- Fetch stream: i_req held, addr 0x0, 0x4, 0x8 on consecutive grants, memory words 0x13, 0xAA, 0xBB -> i_gnt every cycle; i_rvalid the following cycles with 0x13, 0xAA, 0xBB.
- Contention: d_req loads every cycle with i_req held and STARVE_LIMIT = 4 -> d_gnt 4 cycles, then i_gnt once, then repeat; I denied at most 4 cycles.
- Store then load: store 0xDEADBEEF @0x100, then load @0x100 next cycle -> d_rvalid with d_rdata 0 (store ack), then d_rvalid with 0xDEADBEEF.
- Misaligned: d_req load @0x102 with i_req @0x20 -> d_gnt and i_gnt same cycle, mem_read for 0x20 only; next cycle d_err = 1, d_rdata = 0, and i_rvalid with word @0x20.
- Flush: i_flush asserted in the response cycle of fetch @0x40 -> i_rvalid = 0; a grant in that cycle for @0x80 yields i_rvalid next cycle.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// rtl/rv32i_mem_pkg.sv - shared types and constants for the rv32i memory arbiter
package rv32i_mem_pkg;

  // Width of the fetch starvation counter; limits the usable STARVE_LIMIT to 15.
  localparam int STARVE_W = 4;

  // Who owns the memory response arriving in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

  // Canonical RV32I no-op (addi x0, x0, 0).
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32i_arb_starve.sv
// rtl/rv32i_arb_starve.sv - fetch starvation counter and priority override
module rv32i_arb_starve
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic i_prio
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  // Count denied fetch cycles, saturating at the limit; a fetch grant clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt) begin
      cnt_d = '0;
    end else if (i_req && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Once fetch has waited the full limit it wins the next arbitration.
  assign i_prio = i_req && (cnt_q == LIMIT);

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - single-port memory arbiter between fetch and data ports
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic   i_prio;
  logic   d_aligned;
  owner_e owner_q, owner_d;
  logic   err_q, err_d;

  // Fetch addresses are word-aligned by construction; the low bits carry nothing.
  logic   unused_i_addr_lsb;
  assign unused_i_addr_lsb = ^i_addr[1:0];

  assign d_aligned = (d_addr[1:0] == 2'b00);

  rv32i_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_req),
    .i_gnt (i_gnt),
    .i_prio(i_prio)
  );

  // Data wins unless fetch has starved; a misaligned data access leaves the port free for fetch.
  always_comb begin
    d_gnt = rst & d_req & ~i_prio;
    i_gnt = rst & i_req & (~d_gnt | ~d_aligned);
  end

  // Drive the memory port from whichever request actually uses it this cycle.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt && d_aligned) begin
      mem_read  = ~d_we;
      mem_write = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata : 32'h0;
    end else if (i_gnt) begin
      mem_read  = 1'b1;
      mem_addr  = {i_addr[ADDR_W-1:2], 2'b00};
    end
  end

  // Record who owns next cycle's response; a misaligned data access only raises the error flag.
  always_comb begin
    owner_d = OWN_NONE;
    err_d   = d_gnt & ~d_aligned;
    if (d_gnt && d_aligned) begin
      owner_d = d_we ? OWN_D_WR : OWN_D_RD;
    end else if (i_gnt) begin
      owner_d = OWN_I;
    end
  end

  // Response ownership registers; reset drops any response in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Steer the memory read data to its owner; unselected data is zero.
  always_comb begin
    i_rvalid = (owner_q == OWN_I) & ~i_flush;
    i_rdata  = (owner_q == OWN_I) ? mem_rdata : 32'h0;
    d_rvalid = (owner_q == OWN_D_RD) | (owner_q == OWN_D_WR) | err_q;
    d_err    = err_q;
    d_rdata  = (owner_q == OWN_D_RD) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - directed self-checking bench for rv32i_mem_arbiter
module tb_rv32i_mem_arbiter;
  import rv32i_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  rv32i_mem_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_W      (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_flush  (i_flush),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read word memory: a write lands at the edge, so a read one cycle later sees it.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests must stay up until granted.
  logic pend_i = 1'b0;
  logic pend_d = 1'b0;
  always @(negedge clk) begin
    if (rst && pend_i) chk("proto_i_hold", {31'b0, i_req}, 32'd1);
    if (rst && pend_d) chk("proto_d_hold", {31'b0, d_req}, 32'd1);
    pend_i = rst & i_req & ~i_gnt;
    pend_d = rst & d_req & ~d_gnt;
  end

  initial begin
    logic exp_d;
    logic prev_d;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = RV32I_NOP;
    mem[1]  = 32'h0000_00AA;
    mem[2]  = 32'h0000_00BB;
    mem[3]  = 32'h0000_CCCC;
    mem[4]  = 32'h0000_0044;
    mem[8]  = 32'h1111_2222;
    mem[16] = 32'h4040_4040;
    mem[32] = 32'h8080_8080;
    mem_rdata = 32'h0;

    rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'h0;
    #2;
    chk("rst_d_gnt_gated", {31'b0, d_gnt}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_starve_cnt", {28'b0, dut.u_starve.cnt_q}, 32'd0);

    // Load granted, then reset hits while its response is in flight.
    tick(); rst = 1'b1;
    #2;
    chk("load_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("load_mem_read", {31'b0, mem_read}, 32'd1);
    chk("load_mem_addr", mem_addr, 32'h10);
    tick(); d_req = 1'b0;
    #1; rst = 1'b0;
    #1;
    chk("rst_mid_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rst_mid_d_rdata", d_rdata, 32'h0);
    #1; rst = 1'b1;
    tick();
    #2;
    chk("post_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("post_rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("post_rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("post_rst_starve", {28'b0, dut.u_starve.cnt_q}, 32'd0);

    // Back-to-back fetch stream.
    tick(); i_req = 1'b1; i_addr = 32'h0;
    #2;
    chk("fetch0_gnt", {31'b0, i_gnt}, 32'd1);
    chk("fetch0_mem_addr", mem_addr, 32'h0);
    tick(); i_addr = 32'h4;
    #2;
    chk("fetch1_gnt", {31'b0, i_gnt}, 32'd1);
    chk("fetch0_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("fetch0_rdata", i_rdata, 32'h13);
    tick(); i_addr = 32'h8;
    #2;
    chk("fetch2_gnt", {31'b0, i_gnt}, 32'd1);
    chk("fetch1_rdata", i_rdata, 32'hAA);
    tick(); i_req = 1'b0;
    #2;
    chk("fetch_idle_gnt", {31'b0, i_gnt}, 32'd0);
    chk("fetch2_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("fetch2_rdata", i_rdata, 32'hBB);

    // Contention: four data grants, then one forced fetch grant, repeating.
    prev_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); i_req = 1'b1; i_addr = 32'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      #2;
      exp_d = ((k % 5) != 4);
      chk($sformatf("cont%0d_d_gnt", k), {31'b0, d_gnt}, {31'b0, exp_d});
      chk($sformatf("cont%0d_i_gnt", k), {31'b0, i_gnt}, {31'b0, ~exp_d});
      if (k > 0) begin
        chk($sformatf("cont%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, prev_d});
        chk($sformatf("cont%0d_i_rvalid", k), {31'b0, i_rvalid}, {31'b0, ~prev_d});
        if (prev_d) chk($sformatf("cont%0d_d_rdata", k), d_rdata, 32'h44);
      end
      prev_d = exp_d;
    end
    tick(); i_req = 1'b0;
    #2;
    chk("cont_tail_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("cont_tail_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("cont_tail_i_rdata", i_rdata, 32'h0000_CCCC);

    // Store then load of the same word.
    tick(); d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #2;
    chk("store_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("store_mem_write", {31'b0, mem_write}, 32'd1);
    chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store_prev_load_rdata", d_rdata, 32'h44);
    tick(); d_we = 1'b0;
    #2;
    chk("reload_mem_read", {31'b0, mem_read}, 32'd1);
    chk("store_ack_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("store_ack_rdata", d_rdata, 32'h0);
    chk("store_ack_err", {31'b0, d_err}, 32'd0);
    tick(); d_req = 1'b0;
    #2;
    chk("reload_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("reload_rdata", d_rdata, 32'hDEAD_BEEF);

    // Misaligned data access frees the port for a concurrent fetch.
    tick(); d_req = 1'b1; d_addr = 32'h102; i_req = 1'b1; i_addr = 32'h20;
    #2;
    chk("mis_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("mis_i_gnt", {31'b0, i_gnt}, 32'd1);
    chk("mis_mem_read", {31'b0, mem_read}, 32'd1);
    chk("mis_mem_write", {31'b0, mem_write}, 32'd0);
    chk("mis_mem_addr", mem_addr, 32'h20);
    tick(); d_req = 1'b0; i_req = 1'b0;
    #2;
    chk("mis_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("mis_d_err", {31'b0, d_err}, 32'd1);
    chk("mis_d_rdata", d_rdata, 32'h0);
    chk("mis_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("mis_i_rdata", i_rdata, 32'h1111_2222);

    // Flush kills one fetch response but not the grant issued alongside it.
    tick(); i_req = 1'b1; i_addr = 32'h40;
    #2;
    chk("flush_f0_gnt", {31'b0, i_gnt}, 32'd1);
    tick(); i_addr = 32'h80; i_flush = 1'b1;
    #2;
    chk("flush_f1_gnt", {31'b0, i_gnt}, 32'd1);
    chk("flush_f1_mem_addr", mem_addr, 32'h80);
    chk("flush_rvalid", {31'b0, i_rvalid}, 32'd0);
    tick(); i_req = 1'b0; i_flush = 1'b0;
    #2;
    chk("after_flush_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("after_flush_rdata", i_rdata, 32'h8080_8080);
    chk("after_flush_mem_read", {31'b0, mem_read}, 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
